// File: rtl/burst_reader.sv
// burst_reader: credit-limited burst read engine with an in-order return-data FIFO.
// Define BURST_READER_ERR_EN to add response-error handling (rerr_i / err_o).
module burst_reader #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [31:0] base_addr_i,
  input  logic [15:0] len_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        req_o,
  output logic [31:0] addr_o,
  input  logic        gnt_i,
  input  logic        rvalid_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o,
  output logic        valid_o,
  input  logic        ready_i
`ifdef BURST_READER_ERR_EN
  ,
  input  logic        rerr_i,
  output logic        err_o
`endif
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [31:0]   addr_q;
  logic [15:0]   remain_q;
  logic [CW-1:0] outst_q;
  logic [CW-1:0] occ_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic          done_q, done_d;
  logic          finish;
  logic [CW:0]   inflight;
  logic          start_ok, grant, resp, push, pop, err_resp;

  // Outstanding plus buffered words never exceed the FIFO depth, so a push always has room.
  assign inflight = {1'b0, outst_q} + {1'b0, occ_q};
  assign req_o    = (state_q == REQ) && (inflight < DEPTH_C);
  assign addr_o   = addr_q;
  assign grant    = req_o & gnt_i;
  assign resp     = rvalid_i && (outst_q != '0);
  assign valid_o  = (occ_q != '0);
  assign pop      = valid_o & ready_i;
  assign data_o   = valid_o ? mem_q[rd_ptr_q] : '0;
  assign start_ok = (state_q == IDLE) && start_i;
  assign busy_o   = (state_q != IDLE);
  assign done_o   = done_q;

`ifdef BURST_READER_ERR_EN
  logic drop_q;
  logic err_q;

  // After an error response the remaining in-flight responses are consumed but not buffered.
  assign err_resp = resp & rerr_i;
  assign push     = resp & ~rerr_i & ~drop_q;
  assign err_o    = err_q;
`else
  assign err_resp = 1'b0;
  assign push     = resp;
`endif

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) state_d = REQ;
          else             done_d  = 1'b1;
        end
      end
      REQ: begin
        if (err_resp || (grant && remain_q == 16'd1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (outst_q == '0 && occ_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
          finish  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      addr_q   <= '0;
      remain_q <= '0;
      outst_q  <= '0;
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (start_ok && len_i != '0) begin
        addr_q   <= base_addr_i;
        remain_q <= len_i;
      end else if (grant) begin
        addr_q   <= addr_q + 32'd4;
        remain_q <= remain_q - 16'd1;
      end
      if (grant && !resp)      outst_q <= outst_q + CW'(1);
      else if (!grant && resp) outst_q <= outst_q - CW'(1);
      if (push && !pop)      occ_q <= occ_q + CW'(1);
      else if (!push && pop) occ_q <= occ_q - CW'(1);
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rdata_i;
  end

`ifdef BURST_READER_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (start_ok) begin
      drop_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (err_resp) drop_q <= 1'b1;
      if (finish)   err_q  <= drop_q;
    end
  end
`endif

endmodule

// File: tb/tb_burst_reader.sv
// tb_burst_reader: randomized self-checking bench; a memory responder plus expected
// address/data sequences derived from base + 4*i and a fixed address-to-data function.
`timescale 1ns/1ps
module tb_burst_reader;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] base_addr_i = '0;
  logic [15:0] len_i = '0;
  logic        busy_o, done_o, req_o, valid_o;
  logic [31:0] addr_o, data_o;
  logic        gnt_i = 1'b0;
  logic        rvalid_i = 1'b0;
  logic [31:0] rdata_i = '0;
  logic        ready_i = 1'b0;
`ifdef BURST_READER_ERR_EN
  logic        rerr_i = 1'b0;
  logic        err_o;
`endif

  burst_reader #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .req_o(req_o), .addr_o(addr_o), .gnt_i(gnt_i),
    .rvalid_i(rvalid_i), .rdata_i(rdata_i), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i)
`ifdef BURST_READER_ERR_EN
    , .rerr_i(rerr_i), .err_o(err_o)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // scenario knobs
  int gnt_pct, rdy_pct, dly_min, dly_max, hold_gnt, rdy_low_until, restart_at, err_at, snap_cyc;
  bit spurious;

  // observations of the last burst
  logic [31:0] grants[$];
  logic [31:0] got[$];
  logic [31:0] exp_q[$];
  int   done_cnt, done_cyc, stable_viol, credit_viol, req_seen, held_cnt, snap_grants;
  logic busy_c1, snap_req, err_done, err_c1;
  bit   timed_out;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  task automatic set_defaults();
    gnt_pct = 100; rdy_pct = 100; dly_min = 1; dly_max = 1; hold_gnt = 0;
    rdy_low_until = 0; restart_at = -1; err_at = -1; snap_cyc = -1; spurious = 1'b0;
  endtask

  task automatic run_burst(input logic [31:0] base, input logic [15:0] len, input int budget);
    logic [31:0] rq_data[$];
    int          rq_due[$];
    int          resp_idx, cyc, since_done;
    logic        prev_req, prev_gnt, err_seen, is_err;
    logic [31:0] prev_addr;
    grants.delete(); got.delete(); exp_q.delete();
    done_cnt = 0; done_cyc = -1; stable_viol = 0; credit_viol = 0; req_seen = 0; held_cnt = 0;
    snap_grants = -1; snap_req = 1'bx; busy_c1 = 1'bx; err_done = 1'b0; err_c1 = 1'bx;
    timed_out = 1'b0; resp_idx = 0; since_done = 0; prev_req = 1'b0; prev_gnt = 1'b0;
    prev_addr = '0; err_seen = 1'b0;
    @(negedge clk);
    start_i = 1'b1; base_addr_i = base; len_i = len;
    cyc = 0;
    forever begin
      if (cyc > 0) begin
        start_i = (cyc == restart_at);
        if (start_i) begin base_addr_i = 32'hDEAD_0000; len_i = 16'd7; end
      end
      if (done_o) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_cyc = cyc;
`ifdef BURST_READER_ERR_EN
          err_done = err_o;
`endif
        end
      end
      if (cyc == 1) begin
        busy_c1 = busy_o;
`ifdef BURST_READER_ERR_EN
        err_c1 = err_o;
`endif
      end
      if (req_o) req_seen++;
      if (prev_req && !prev_gnt && (!req_o || addr_o !== prev_addr)) stable_viol++;
      if (cyc == snap_cyc) begin snap_grants = grants.size(); snap_req = req_o; end
      // memory-side stimulus for the coming edge
      if (req_o && grants.size() == 0 && held_cnt < hold_gnt) begin
        gnt_i = 1'b0;
        held_cnt++;
      end else begin
        gnt_i = req_o && ($urandom_range(0, 99) < gnt_pct);
      end
      ready_i = (cyc >= rdy_low_until) && ($urandom_range(0, 99) < rdy_pct);
      is_err = 1'b0;
      if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
        rvalid_i = 1'b1;
        rdata_i = rq_data.pop_front();
        void'(rq_due.pop_front());
        resp_idx++;
        is_err = (resp_idx == err_at);
        if (!is_err && !err_seen) exp_q.push_back(rdata_i);
        if (is_err) err_seen = 1'b1;
      end else if (spurious && grants.size() == resp_idx && $urandom_range(0, 7) == 0) begin
        rvalid_i = 1'b1;
        rdata_i = 32'hBAD0_0000 | cyc;
      end else begin
        rvalid_i = 1'b0;
      end
`ifdef BURST_READER_ERR_EN
      rerr_i = is_err;
`endif
      if (req_o && gnt_i) begin
        grants.push_back(addr_o);
        rq_data.push_back(mem_f(addr_o));
        rq_due.push_back(cyc + $urandom_range(dly_min, dly_max));
      end
      if (valid_o && ready_i) got.push_back(data_o);
      if (!err_seen && (grants.size() - got.size()) > int'(DEPTH)) credit_viol++;
      prev_req = req_o; prev_gnt = gnt_i; prev_addr = addr_o;
      if (done_cnt > 0) since_done++;
      if (since_done >= 4) break;
      if (cyc >= budget) begin timed_out = 1'b1; break; end
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0; gnt_i = 1'b0; rvalid_i = 1'b0; ready_i = 1'b0;
`ifdef BURST_READER_ERR_EN
    rerr_i = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", req_o); end
    n_checks++; if (addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", addr_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done_o); end
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    n_checks++; if (data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", data_o); end
`ifdef BURST_READER_ERR_EN
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err_o); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (busy_o !== 1'b0 || req_o !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: busy %b req %b expected 0 0", busy_o, req_o); end
  endtask

  // Shared end-of-burst comparison of addresses and delivered data against base + 4*i.
  task automatic test_stream(input string name, input logic [31:0] base, input int len);
    logic [31:0] a;
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL %s_timeout: burst did not complete, done count %0d expected 1", name, done_cnt); end
    n_checks++; if (grants.size() != len) begin n_fail++; $display("FAIL %s_grant_count: got %0d expected %0d", name, grants.size(), len); end
    n_checks++; if (got.size() != len) begin n_fail++; $display("FAIL %s_word_count: got %0d expected %0d", name, got.size(), len); end
    for (int i = 0; i < len; i++) begin
      a = base + 32'(4 * i);
      if (i < grants.size()) begin
        n_checks++; if (grants[i] !== a) begin n_fail++; $display("FAIL %s_addr[%0d]: got %h expected %h", name, i, grants[i], a); end
      end
      if (i < got.size()) begin
        n_checks++; if (got[i] !== mem_f(a)) begin n_fail++; $display("FAIL %s_data[%0d]: got %h expected %h", name, i, got[i], mem_f(a)); end
      end
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL %s_done_pulses: got %0d expected 1", name, done_cnt); end
    n_checks++; if (busy_c1 !== 1'b1) begin n_fail++; $display("FAIL %s_busy_after_start: got %b expected 1", name, busy_c1); end
    n_checks++; if (stable_viol != 0) begin n_fail++; $display("FAIL %s_req_stable: got %0d violations expected 0", name, stable_viol); end
    n_checks++; if (credit_viol != 0) begin n_fail++; $display("FAIL %s_credit: got %0d violations expected 0", name, credit_viol); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL %s_busy_end: got %b expected 0", name, busy_o); end
  endtask

  task automatic test_basic();
    set_defaults();
    run_burst(32'h0000_1000, 16'd4, 200);
    test_stream("basic", 32'h0000_1000, 4);
  endtask

  task automatic test_wrap();
    set_defaults();
    run_burst(32'hFFFF_FFF8, 16'd3, 200);
    test_stream("wrap", 32'hFFFF_FFF8, 3);
  endtask

  task automatic test_backpressure();
    set_defaults();
    rdy_low_until = 30; snap_cyc = 29;
    run_burst(32'h0000_4000, 16'd8, 400);
    n_checks++; if (snap_grants != int'(DEPTH)) begin n_fail++; $display("FAIL bp_grants_while_stalled: got %0d expected %0d", snap_grants, DEPTH); end
    n_checks++; if (snap_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_while_full: got %b expected 0", snap_req); end
    test_stream("bp", 32'h0000_4000, 8);
  endtask

  task automatic test_gnt_stall();
    set_defaults();
    hold_gnt = 5; restart_at = 3;
    run_burst(32'h0000_5000, 16'd3, 200);
    n_checks++; if (held_cnt != 5) begin n_fail++; $display("FAIL stall_req_held: got %0d cycles expected 5", held_cnt); end
    test_stream("stall", 32'h0000_5000, 3);
  endtask

  task automatic test_len_zero();
    set_defaults();
    run_burst(32'h0000_6000, 16'd0, 50);
    n_checks++; if (done_cyc != 1) begin n_fail++; $display("FAIL len0_done_latency: got %0d expected 1", done_cyc); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL len0_done_pulses: got %0d expected 1", done_cnt); end
    n_checks++; if (req_seen != 0) begin n_fail++; $display("FAIL len0_req: got %0d req cycles expected 0", req_seen); end
    n_checks++; if (busy_c1 !== 1'b0) begin n_fail++; $display("FAIL len0_busy: got %b expected 0", busy_c1); end
  endtask

  task automatic test_reset_abort();
    int anomalies;
    @(negedge clk);
    start_i = 1'b1; base_addr_i = 32'h0000_2000; len_i = 16'd6;
    @(negedge clk);
    start_i = 1'b0;
    n_checks++; if (req_o !== 1'b1 || addr_o !== 32'h0000_2000) begin n_fail++; $display("FAIL abort_first_req: got req %b addr %h expected 1 00002000", req_o, addr_o); end
    gnt_i = 1'b1;
    @(negedge clk);
    gnt_i = 1'b1; rvalid_i = 1'b1; rdata_i = 32'h1111_2222;
    @(negedge clk);
    gnt_i = 1'b0; rvalid_i = 1'b0;
    n_checks++; if (valid_o !== 1'b1 || data_o !== 32'h1111_2222) begin n_fail++; $display("FAIL abort_buffered: got valid %b data %h expected 1 11112222", valid_o, data_o); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if ({req_o, busy_o, done_o, valid_o} !== 4'b0000 || addr_o !== '0 || data_o !== '0) begin
      n_fail++; $display("FAIL abort_async_reset: got req %b busy %b done %b valid %b addr %h data %h expected all 0", req_o, busy_o, done_o, valid_o, addr_o, data_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    anomalies = 0;
    for (int i = 0; i < 8; i++) begin
      rvalid_i = (i == 1); rdata_i = 32'h3333_4444;
      if (done_o || valid_o || req_o || busy_o) anomalies++;
      @(negedge clk);
    end
    rvalid_i = 1'b0;
    n_checks++; if (anomalies != 0) begin n_fail++; $display("FAIL abort_quiet_after_reset: got %0d active cycles expected 0", anomalies); end
  endtask

  task automatic test_random();
    logic [31:0] base;
    int          len;
    for (int n = 0; n < 12; n++) begin
      set_defaults();
      gnt_pct = $urandom_range(30, 100); rdy_pct = $urandom_range(25, 100);
      dly_min = 1; dly_max = $urandom_range(1, 4); spurious = 1'b1;
      base = (n % 4 == 3) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4)) : ($urandom & 32'hFFFF_FFFC);
      len = $urandom_range(1, 12);
      run_burst(base, 16'(len), 2000);
      test_stream("random", base, len);
    end
  endtask

`ifdef BURST_READER_ERR_EN
  task automatic test_error();
    set_defaults();
    err_at = 2;
    run_burst(32'h0000_3000, 16'd4, 200);
    n_checks++; if (timed_out || done_cnt != 1) begin n_fail++; $display("FAIL err_done: got %0d pulses timeout %b expected 1 0", done_cnt, timed_out); end
    n_checks++; if (got.size() != 1) begin n_fail++; $display("FAIL err_word_count: got %0d expected 1", got.size()); end
    if (got.size() > 0) begin
      n_checks++; if (got[0] !== mem_f(32'h0000_3000)) begin n_fail++; $display("FAIL err_first_word: got %h expected %h", got[0], mem_f(32'h0000_3000)); end
    end
    n_checks++; if (grants.size() >= 4) begin n_fail++; $display("FAIL err_no_more_requests: got %0d grants expected below 4", grants.size()); end
    n_checks++; if (err_done !== 1'b1) begin n_fail++; $display("FAIL err_at_done: got %b expected 1", err_done); end
    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_held: got %b expected 1", err_o); end
    set_defaults();
    run_burst(32'h0000_3100, 16'd1, 200);
    n_checks++; if (err_c1 !== 1'b0) begin n_fail++; $display("FAIL err_cleared_by_start: got %b expected 0", err_c1); end
    test_stream("err_next", 32'h0000_3100, 1);
  endtask
`endif

  initial begin
    set_defaults();
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_gnt_stall();
    test_len_zero();
    test_reset_abort();
    test_random();
`ifdef BURST_READER_ERR_EN
    test_error();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
